brent_kung_pipe: RTL and testbench
==================================

# brent_kung_pipe

Parametrised, pipelined Brent-Kung prefix adder/subtractor with valid/ready handshaking and a carry flag for multi-word chained arithmetic. It is the datapath successor of the fixed 32-bit combinational Brent-Kung adder in the prefix-adder (ppas) family. It serves as the integer add/sub unit wherever a registered, back-pressurable adder of arbitrary power-of-two width is needed.

## Interface
- WIDTH, 32: operand width; power of two, 4..64.
- MID_REG, 1: 1 inserts a register between the up-sweep (group G/P tree) and the down-sweep/sum stage; 0 omits it.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- a, b  in  WIDTH  operands.
- cin  in  1  carry-in; used by ADD only.
- op  in  2  00 ADD a+b+cin; 01 SUB a+~b+1; 10 ADDC a+b+flag; 11 SUBC a+~b+flag.
- clr_flag  in  1  synchronous clear of carry_flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry-out; for SUB/SUBC, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  s == 0.
- carry_flag  out  1  architectural carry register.

## Operation
- Accept: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Stage 1 (input register, always present): latches a, b_eff (b for ADD/ADDC, ~b for SUB/SUBC), cin_eff, op.
- cin_eff = cin (ADD), 1 (SUB), eff_flag (ADDC/SUBC), where eff_flag = clr_flag ? 0 : carry_flag, sampled in the accept cycle.
- Stage 2 (present only if MID_REG=1): computes bitwise G=a&b_eff and P=a^b_eff, then log2(WIDTH) Brent-Kung up-sweep levels; registers the group G/P spans ending at bits 2^k-1.
- Output stage: down-sweep fills all prefix carries, including cin_eff as carry into bit 0; registers s, cout, ovf, zero.
- ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]).
- zero = (s == 0).
- The prefix tree structure is generic in WIDTH: up-sweep then down-sweep, with no ripple sections.
- carry_flag updates to cout on each output handshake, for every op. clr_flag asserted in the same cycle forces it to 0; clear wins.
- Chaining hazard: while op[1]=1 and any stage holds a valid beat, in_ready=0. An ADDC/SUBC therefore enters only after every older result has been handshaken. in_ready depends combinationally on op; this is permitted.
- Otherwise in_ready = stage 1 empty or stage 1 advancing.
- Each stage loads when it is empty or its downstream stage loads. Bubbles collapse; results stay strictly in order; there is no loss or duplication.
- While out_valid=1 && out_ready=0, s, cout, ovf and zero hold stable.

## Timing
- Latency, accept edge to out_valid: 2 cycles (MID_REG=0) or 3 cycles (MID_REG=1).
- Throughput: 1 op/cycle for ADD/SUB with out_ready=1.
- An ADDC/SUBC following an op issues at the earliest the cycle after that op's output handshake.
- Reset (rst_n=0, asynchronous): all stage valids = 0, out_valid=0, s=0, cout=0, ovf=0, zero=0, carry_flag=0; in_ready=0 while in reset. In-flight beats are discarded with no stale output after release.
- First accept is possible in the first clock edge after rst_n deasserts.
- Simultaneous accept and output handshake in a full pipeline: both occur, and occupancy is unchanged.
- clr_flag with no handshake: carry_flag=0 next edge.

## Test plan
- WIDTH=32, MID_REG=1. Reset, then ADD a=0xFFFFFFFF b=0x00000001 cin=0 -> 3 cycles later s=0, cout=1, zero=1, ovf=0; carry_flag=1 after handshake.
- SUB 5-7 -> s=0xFFFFFFFE, cout=0, ovf=0. SUB 0x80000000-1 -> s=0x7FFFFFFF, cout=1, ovf=1. ADD 0x7FFFFFFF+1 cin=0 -> s=0x80000000, ovf=1.
- 64-bit chain: ADD lo 0xFFFFFFFF+0x1 cin=0 issued, then ADDC hi 0x1+0x2 presented next cycle -> in_ready=0 until lo handshakes; hi s=0x4, cout=0. SUBC with clr_flag=1 in its accept cycle uses flag 0.
- 200 random ADD/SUB beats, in_valid random, out_ready pattern 1,0,1,1,0 -> results in order, each equals the reference model, held stable while stalled. Repeat for WIDTH=8 and 64, with MID_REG=0 and 1.
- Assert rst_n=0 asynchronously mid-cycle with 3 beats in flight -> out_valid and carry_flag drop immediately; after release, no output until a new accept.
- clr_flag asserted on the same edge as an output handshake with cout=1 -> carry_flag=0.

Source files
------------

// File: rtl/brent_kung_pipe.sv
// Pipelined Brent-Kung prefix adder/subtractor with valid/ready flow control and an
// architectural carry flag so ADDC/SUBC can chain multi-word arithmetic.
module brent_kung_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MID_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic             clr_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             carry_flag
);

  localparam int Lg = $clog2(WIDTH);

  logic             flag_q;
  logic             v1_q, c1_q;
  logic [WIDTH-1:0] a1_q, b1_q;
  logic             vo_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0] s_q;

  logic             eff_flag, cin_eff, accept, busy;
  logic [WIDTH-1:0] b_eff;
  logic             load_o, s1_adv, v_pre;

  logic [WIDTH-1:0] gu, pu, pb;
  logic [WIDTH-1:0] gu_pre, pu_pre, pb_pre;
  logic             c_pre, am_pre;

  logic [WIDTH-1:0] gd, pd, sum;
  logic [WIDTH:0]   carry;

  always_comb begin
    eff_flag = clr_flag ? 1'b0 : flag_q;
    b_eff    = op[0] ? ~b : b;
    case (op)
      2'b00:   cin_eff = cin;
      2'b01:   cin_eff = 1'b1;
      default: cin_eff = eff_flag;
    endcase
  end

  assign load_o   = !vo_q || out_ready;
  assign busy     = v1_q || v_pre || vo_q;
  // A chained op must see the flag left behind by every older result.
  assign in_ready = rst_n && !(op[1] && busy) && (!v1_q || s1_adv);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      c1_q <= 1'b0;
    end else begin
      if (!v1_q || s1_adv) v1_q <= accept;
      if (accept) begin
        a1_q <= a;
        b1_q <= b_eff;
        c1_q <= cin_eff;
      end
    end
  end

  // Up-sweep: node i = k*2^(l+1)-1 absorbs the span ending at i - 2^l.
  always_comb begin
    pb = a1_q ^ b1_q;
    gu = a1_q & b1_q;
    pu = pb;
    for (int l = 0; l < Lg; l++) begin
      for (int i = (2 << l) - 1; i < int'(WIDTH); i += 2 << l) begin
        gu[i] = gu[i] | (pu[i] & gu[i - (1 << l)]);
        pu[i] = pu[i] & pu[i - (1 << l)];
      end
    end
  end

  if (MID_REG != 0) begin : g_mid
    logic             v2_q, c2_q, am2_q;
    logic [WIDTH-1:0] gu2_q, pu2_q, pb2_q;

    assign s1_adv = !v2_q || load_o;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q  <= 1'b0;
        gu2_q <= '0;
        pu2_q <= '0;
        pb2_q <= '0;
        c2_q  <= 1'b0;
        am2_q <= 1'b0;
      end else begin
        if (s1_adv) v2_q <= v1_q;
        if (s1_adv && v1_q) begin
          gu2_q <= gu;
          pu2_q <= pu;
          pb2_q <= pb;
          c2_q  <= c1_q;
          am2_q <= a1_q[WIDTH-1];
        end
      end
    end

    assign v_pre  = v2_q;
    assign gu_pre = gu2_q;
    assign pu_pre = pu2_q;
    assign pb_pre = pb2_q;
    assign c_pre  = c2_q;
    assign am_pre = am2_q;
  end else begin : g_flat
    assign s1_adv = load_o;
    assign v_pre  = v1_q;
    assign gu_pre = gu;
    assign pu_pre = pu;
    assign pb_pre = pb;
    assign c_pre  = c1_q;
    assign am_pre = a1_q[WIDTH-1];
  end

  // Down-sweep fills the remaining prefixes; cin joins as the carry into bit 0.
  always_comb begin
    gd    = gu_pre;
    pd    = pu_pre;
    carry = '0;
    for (int l = Lg - 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < int'(WIDTH); i += 2 << l) begin
        gd[i] = gd[i] | (pd[i] & gd[i - (1 << l)]);
        pd[i] = pd[i] & pd[i - (1 << l)];
      end
    end
    carry[0] = c_pre;
    for (int i = 0; i < int'(WIDTH); i++) begin
      carry[i + 1] = gd[i] | (pd[i] & c_pre);
    end
    sum = pb_pre ^ carry[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vo_q   <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (load_o) vo_q <= v_pre;
      if (load_o && v_pre) begin
        s_q    <= sum;
        cout_q <= carry[WIDTH];
        ovf_q  <= !pb_pre[WIDTH-1] && (sum[WIDTH-1] != am_pre);
        zero_q <= (sum == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else if (clr_flag) begin
      flag_q <= 1'b0;
    end else if (vo_q && out_ready) begin
      flag_q <= cout_q;
    end
  end

  assign out_valid  = vo_q;
  assign s          = s_q;
  assign cout       = cout_q;
  assign ovf        = ovf_q;
  assign zero       = zero_q;
  assign carry_flag = flag_q;

endmodule

// File: tb/tb_brent_kung_pipe.sv
// Bench for brent_kung_pipe: directed corner cases on a 32-bit MID_REG=1 instance plus
// random ADD/SUB streams on several WIDTH/MID_REG variants against an arithmetic model.
module tb_brent_kung_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst_x = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  logic        m_in_valid, m_in_ready, m_cin, m_clr, m_out_valid, m_out_ready;
  logic        m_cout, m_ovf, m_zero, m_flag;
  logic [1:0]  m_op;
  logic [31:0] m_a, m_b, m_s;

  brent_kung_pipe #(.WIDTH(32), .MID_REG(1)) u_main (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (m_in_valid),
    .in_ready   (m_in_ready),
    .a          (m_a),
    .b          (m_b),
    .cin        (m_cin),
    .op         (m_op),
    .clr_flag   (m_clr),
    .out_valid  (m_out_valid),
    .out_ready  (m_out_ready),
    .s          (m_s),
    .cout       (m_cout),
    .ovf        (m_ovf),
    .zero       (m_zero),
    .carry_flag (m_flag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!m_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!m_in_ready) check({tag, " ready timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!m_out_valid) check({tag, " valid timeout"}, 64'd0, 64'd1);
  endtask

  // Issue one op, wait for its result with out_ready=1, compare, then handshake it.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic ci, input logic cl,
                       input logic [31:0] es, input logic ec, input logic eo, input logic ez);
    m_op = o; m_a = x; m_b = y; m_cin = ci; m_clr = cl;
    m_in_valid = 1'b1; m_out_ready = 1'b1;
    #1;
    wait_ready(tag);
    tick();
    m_in_valid = 1'b0; m_clr = 1'b0;
    wait_valid(tag);
    check({tag, " s"}, m_s, es);
    check({tag, " cout"}, m_cout, ec);
    check({tag, " ovf"}, m_ovf, eo);
    check({tag, " zero"}, m_zero, ez);
    tick();
  endtask

  // Random ADD/SUB streams on several configurations, each with its own DUT and model.
  for (genvar k = 0; k < 5; k++) begin : g_rnd
    localparam int W  = (k == 0) ? 32 : (k < 3) ? 8 : 64;
    localparam int MR = (k % 2 == 0) ? 1 : 0;

    logic         iv, ir, ci, ov, orr, co, of, zr, fl;
    logic [1:0]   op;
    logic [W-1:0] x, y, sm;
    logic [W+2:0] exp_q[$];
    bit           fin = 1'b0;

    brent_kung_pipe #(.WIDTH(W), .MID_REG(MR)) u_dut (
      .clk        (clk),
      .rst_n      (rst_x),
      .in_valid   (iv),
      .in_ready   (ir),
      .a          (x),
      .b          (y),
      .cin        (ci),
      .op         (op),
      .clr_flag   (1'b0),
      .out_valid  (ov),
      .out_ready  (orr),
      .s          (sm),
      .cout       (co),
      .ovf        (of),
      .zero       (zr),
      .carry_flag (fl)
    );

    initial begin
      int           sent, got, cyc;
      bit           held;
      string        pfx;
      logic [W-1:0] held_s;
      logic [W+2:0] e;
      logic [W:0]   full;
      logic [W+1:0] ea, eb, r;
      logic [63:0]  t;
      iv = 1'b0; ci = 1'b0; op = 2'b00; x = '0; y = '0; orr = 1'b0;
      sent = 0; got = 0; cyc = 0; held = 1'b0; held_s = '0;
      pfx = $sformatf("rnd w%0d m%0d", W, MR);
      @(negedge rst_x);
      wait (rst_x === 1'b1);
      while (got < 200 && cyc < 4000) begin
        tick();
        if (held) begin
          check({pfx, " hold valid"}, 64'(ov), 64'd1);
          check({pfx, " hold s"}, 64'(sm), 64'(held_s));
        end
        t = {$urandom, $urandom}; x = t[W-1:0];
        t = {$urandom, $urandom}; y = t[W-1:0];
        if ($urandom_range(0, 7) == 0) x = '1;
        if ($urandom_range(0, 7) == 0) y = (sent % 2 == 0) ? '0 : '1;
        ci  = 1'($urandom_range(0, 1));
        op  = {1'b0, 1'($urandom_range(0, 1))};
        iv  = (sent < 200) && ($urandom_range(0, 3) != 0);
        orr = (cyc % 5 != 1) && (cyc % 5 != 4);
        #1;
        if (iv && ir) begin
          ea = {{2{x[W-1]}}, x};
          eb = {{2{y[W-1]}}, y};
          if (op[0]) begin
            e[W-1:0] = x - y;
            e[W]     = (x >= y);
            r        = ea - eb;
          end else begin
            full     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            e[W-1:0] = full[W-1:0];
            e[W]     = full[W];
            r        = ea + eb + {{(W + 1){1'b0}}, ci};
          end
          e[W+1] = (r[W] != r[W-1]);
          e[W+2] = (e[W-1:0] == '0);
          exp_q.push_back(e);
          sent++;
        end
        if (ov && orr) begin
          if (exp_q.size() == 0) begin
            check({pfx, " unexpected result"}, 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check({pfx, " s"}, 64'(sm), 64'(e[W-1:0]));
            check({pfx, " cout"}, 64'(co), 64'(e[W]));
            check({pfx, " ovf"}, 64'(of), 64'(e[W+1]));
            check({pfx, " zero"}, 64'(zr), 64'(e[W+2]));
          end
          got++;
        end
        held   = ov && !orr;
        held_s = sm;
        cyc++;
      end
      if (got < 200) check({pfx, " drain timeout"}, 64'(got), 64'd200);
      iv  = 1'b0;
      fin = 1'b1;
    end
  end

  initial begin
    int n;
    m_in_valid = 1'b0; m_cin = 1'b0; m_clr = 1'b0; m_out_ready = 1'b0;
    m_op = 2'b00; m_a = '0; m_b = '0;
    #1;
    rst_n = 1'b0;
    rst_x = 1'b0;
    #1;
    check("reset out_valid", m_out_valid, 0);
    check("reset in_ready", m_in_ready, 0);
    check("reset s", m_s, 0);
    check("reset cout", m_cout, 0);
    check("reset ovf", m_ovf, 0);
    check("reset zero", m_zero, 0);
    check("reset flag", m_flag, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rst_x = 1'b1;

    // First beat: accepted on the first edge after release; three register stages deep.
    m_op = 2'b00; m_a = 32'hFFFF_FFFF; m_b = 32'h1; m_cin = 1'b0; m_in_valid = 1'b1;
    #1;
    check("first in_ready", m_in_ready, 1);
    tick();
    m_in_valid = 1'b0;
    check("lat edge1 valid", m_out_valid, 0);
    tick();
    check("lat edge2 valid", m_out_valid, 0);
    tick();
    check("lat edge3 valid", m_out_valid, 1);
    check("add wrap s", m_s, 0);
    check("add wrap cout", m_cout, 1);
    check("add wrap zero", m_zero, 1);
    check("add wrap ovf", m_ovf, 0);
    check("flag before hs", m_flag, 0);
    m_out_ready = 1'b1;
    tick();
    check("flag after hs", m_flag, 1);
    check("valid after hs", m_out_valid, 0);

    do_op("sub 5-7", 2'b01, 32'd5, 32'd7, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    check("flag after borrow", m_flag, 0);
    do_op("sub min-1", 2'b01, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1,
          1'b0);
    do_op("add max+1", 2'b00, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1,
          1'b0);

    // 64-bit chain: ADDC must wait until the low word has been handshaken.
    m_op = 2'b00; m_a = 32'hFFFF_FFFF; m_b = 32'h1; m_cin = 1'b0;
    m_in_valid = 1'b1; m_out_ready = 1'b1;
    #1;
    wait_ready("chain lo");
    tick();
    m_op = 2'b10; m_a = 32'h1; m_b = 32'h2;
    #1;
    n = 0;
    while (!m_in_ready && n < 20) begin
      tick();
      n++;
    end
    check("chain stall cycles", n, 3);
    check("chain flag", m_flag, 1);
    tick();
    m_in_valid = 1'b0;
    wait_valid("chain hi");
    check("chain hi s", m_s, 32'h4);
    check("chain hi cout", m_cout, 0);
    tick();
    check("chain flag after hi", m_flag, 0);

    // SUBC with clr_flag in its accept cycle uses flag 0: 5 - 3 - 1 = 1.
    do_op("set flag", 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("flag set", m_flag, 1);
    do_op("subc clr", 2'b11, 32'd5, 32'd3, 1'b0, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    check("flag after subc", m_flag, 1);
    m_clr = 1'b1;
    tick();
    m_clr = 1'b0;
    check("clr idle", m_flag, 0);

    // clr_flag on the same edge as a handshake carrying cout=1: clear wins.
    m_op = 2'b00; m_a = 32'hFFFF_FFFF; m_b = 32'h1; m_cin = 1'b0;
    m_in_valid = 1'b1; m_out_ready = 1'b0;
    #1;
    wait_ready("clr hs");
    tick();
    m_in_valid = 1'b0;
    wait_valid("clr hs");
    check("clr hs pending cout", m_cout, 1);
    m_clr = 1'b1; m_out_ready = 1'b1;
    tick();
    m_clr = 1'b0;
    check("clr beats hs", m_flag, 0);
    check("clr hs drained", m_out_valid, 0);

    // Asynchronous reset with three beats in flight.
    do_op("pre reset", 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    m_out_ready = 1'b0; m_op = 2'b00; m_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_a = 32'(i + 10); m_b = 32'd1;
      #1;
      check("fill in_ready", m_in_ready, 1);
      tick();
    end
    m_in_valid = 1'b0;
    check("full out_valid", m_out_valid, 1);
    check("full flag", m_flag, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", m_out_valid, 0);
    check("async rst flag", m_flag, 0);
    check("async rst in_ready", m_in_ready, 0);
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    m_out_ready = 1'b1;
    n = 0;
    repeat (6) begin
      tick();
      if (m_out_valid) n++;
    end
    check("no stale output", n, 0);
    do_op("post reset", 2'b00, 32'd2, 32'd3, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);

    n = 0;
    while (!(g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin && g_rnd[3].fin && g_rnd[4].fin)
           && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) check("random streams timeout", 64'd0, 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
